// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: opcode encodings, unit decode and the result record.
package alu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REGIDX_W = 5;

    typedef enum logic [4:0] {
        OpAdd  = 5'd0,
        OpSub  = 5'd1,
        OpSlt  = 5'd2,
        OpSltu = 5'd3,
        OpXor  = 5'd4,
        OpOr   = 5'd6,
        OpAnd  = 5'd7,
        OpSll  = 5'd8,
        OpSrl  = 5'd12,
        OpSra  = 5'd13
    } alu_op_e;

    typedef enum logic [2:0] {
        UnitAdder,
        UnitLogic,
        UnitCmp,
        UnitShift,
        UnitNone
    } alu_unit_e;

    typedef struct packed {
        logic [XLEN-1:0]     data;
        logic [REGIDX_W-1:0] rd;
        logic                we;
    } alu_res_t;

    // Encodings outside the table (5, 9-11, 14-31) decode to UnitNone and count as illegal.
    function automatic alu_unit_e op_to_unit(alu_op_e op);
        alu_unit_e unit;
        case (op)
            OpAdd, OpSub:        unit = UnitAdder;
            OpSlt, OpSltu:       unit = UnitCmp;
            OpXor, OpOr, OpAnd:  unit = UnitLogic;
            OpSll, OpSrl, OpSra: unit = UnitShift;
            default:             unit = UnitNone;
        endcase
        return unit;
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Issue and writeback signals of the ALU result stage.
// master = upstream issuer plus writeback consumer; slave = the result stage itself.
interface alu_result_stage_if;
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [4:0]          Instruction_to_ALU;
    logic [XLEN-1:0]     Shifter_out;
    logic [XLEN-1:0]     Adder_out;
    logic [XLEN-1:0]     Logic_out;
    logic                Compare_out;
    logic [REGIDX_W-1:0] in_rd;
    logic                in_flush;
    logic                wb_valid;
    logic                wb_ready;
    logic [XLEN-1:0]     wb_data;
    logic [REGIDX_W-1:0] wb_rd;
    logic                wb_we;
    logic                err_illegal;

    modport master (
        output in_valid, Instruction_to_ALU, Shifter_out, Adder_out, Logic_out, Compare_out,
               in_rd, in_flush, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_rd, wb_we, err_illegal
    );

    modport slave (
        input  in_valid, Instruction_to_ALU, Shifter_out, Adder_out, Logic_out, Compare_out,
               in_rd, in_flush, wb_ready,
        output in_ready, wb_valid, wb_data, wb_rd, wb_we, err_illegal
    );

endinterface

// File: rtl/alu_result_skid.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid slot.
// in_ready_o is decoded from registered occupancy only, so it never depends on out_ready_i.
module alu_result_skid #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

    occ_e state_q, state_d;
    T     out_q, out_d;
    T     skid_q, skid_d;
    logic accept;
    logic drain;

    always_comb begin
        in_ready_o  = (state_q != StTwo);
        out_valid_o = (state_q != StEmpty);
        out_data_o  = out_q;
        accept      = in_valid_i & in_ready_o;
        drain       = out_valid_o & out_ready_i;
        state_d     = state_q;
        out_d       = out_q;
        skid_d      = skid_q;
        // Flush wins over any same-cycle accept.
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        out_d   = in_data_i;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        out_d = in_data_i;
                    end else if (accept) begin
                        skid_d  = in_data_i;
                        state_d = StTwo;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (drain) begin
                        out_d   = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: selects the ALU unit result, tags it with rd and hands it to writeback.
// Optional ALU_RESULT_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs.
module alu_result_stage
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    alu_result_stage_if.slave   bus
`ifdef ALU_RESULT_FWD_EN
    ,
    output logic                fwd_valid,
    output logic [REGIDX_W-1:0] fwd_rd,
    output logic [XLEN-1:0]     fwd_data
`endif
);

    alu_op_e   op;
    alu_unit_e unit;
    alu_res_t  in_res;
    alu_res_t  out_res;
    logic      in_ready;
    logic      out_valid;
    logic      accept;
    logic      err_q, err_d;

    always_comb begin
        op          = alu_op_e'(bus.Instruction_to_ALU);
        unit        = op_to_unit(op);
        in_res      = '0;
        case (unit)
            UnitAdder: in_res.data = bus.Adder_out;
            UnitLogic: in_res.data = bus.Logic_out;
            UnitCmp:   in_res.data = {{(XLEN-1){1'b0}}, bus.Compare_out};
            UnitShift: in_res.data = bus.Shifter_out;
            default:   in_res.data = '0;
        endcase
        in_res.rd   = bus.in_rd;
        in_res.we   = (bus.in_rd != '0) && (unit != UnitNone);
        accept      = bus.in_valid & in_ready;
        err_d       = err_q | (accept & ~bus.in_flush & (unit == UnitNone));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    alu_result_skid #(
        .T (alu_res_t)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.in_flush),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_res),
        .out_valid_o (out_valid),
        .out_ready_i (bus.wb_ready),
        .out_data_o  (out_res)
    );

    assign bus.in_ready    = in_ready;
    assign bus.wb_valid    = out_valid;
    assign bus.wb_data     = out_res.data;
    assign bus.wb_rd       = out_res.rd;
    assign bus.wb_we       = out_res.we;
    assign bus.err_illegal = err_q;

`ifdef ALU_RESULT_FWD_EN
    assign fwd_valid = out_valid & out_res.we;
    assign fwd_rd    = out_res.rd;
    assign fwd_data  = out_res.data;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (fwd_* checked when ALU_RESULT_FWD_EN is defined).
module tb_alu_result_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_result_stage_if bus ();

`ifdef ALU_RESULT_FWD_EN
    logic                fwd_valid;
    logic [REGIDX_W-1:0] fwd_rd;
    logic [XLEN-1:0]     fwd_data;
`endif

    alu_result_stage dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ALU_RESULT_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] adder, input logic [4:0] rd);
        bus.in_valid           = 1'b1;
        bus.Instruction_to_ALU = op;
        bus.Adder_out          = adder;
        bus.in_rd              = rd;
    endtask

    task automatic test_reset();
        rst                    = 1'b1;
        bus.in_valid           = 1'b0;
        bus.Instruction_to_ALU = 5'd0;
        bus.Shifter_out        = '0;
        bus.Adder_out          = '0;
        bus.Logic_out          = '0;
        bus.Compare_out        = 1'b0;
        bus.in_rd              = '0;
        bus.in_flush           = 1'b0;
        bus.wb_ready           = 1'b0;
        #3;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%0b want=0", bus.wb_valid); end
        checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got=%h want=0", bus.wb_data); end
        checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got=%0d want=0", bus.wb_rd); end
        checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we got=%0b want=0", bus.wb_we); end
        checks++; if (bus.err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", bus.err_illegal); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
        #9 rst = 1'b0;
        step();
    endtask

    task automatic test_select();
        logic [4:0]  vop  [10];
        logic [31:0] vexp [10];
        vop  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd12, 5'd13};
        vexp = '{32'h1111_1111, 32'h1111_1111, 32'h1, 32'h1, 32'h2222_2222, 32'h2222_2222,
                 32'h2222_2222, 32'h3333_3333, 32'h3333_3333, 32'h3333_3333};
        bus.wb_ready           = 1'b1;
        bus.in_valid           = 1'b1;
        bus.Instruction_to_ALU = 5'd8;
        bus.Shifter_out        = 32'h0000_0F00;
        bus.in_rd              = 5'd3;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL sll_valid got=%0b want=1", bus.wb_valid); end
        checks++; if (bus.wb_data !== 32'h0F00) begin errors++; $display("FAIL sll_data got=%h want=00000f00", bus.wb_data); end
        checks++; if (bus.wb_rd !== 5'd3) begin errors++; $display("FAIL sll_rd got=%0d want=3", bus.wb_rd); end
        checks++; if (bus.wb_we !== 1'b1) begin errors++; $display("FAIL sll_we got=%0b want=1", bus.wb_we); end
`ifdef ALU_RESULT_FWD_EN
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd3 || fwd_data !== 32'h0F00) begin
            errors++; $display("FAIL sll_fwd got=%0b/%0d/%h want=1/3/00000f00", fwd_valid, fwd_rd, fwd_data);
        end
`endif
        step();
        // Back-to-back stream over every legal opcode with distinct per-unit values.
        bus.Adder_out   = 32'h1111_1111;
        bus.Logic_out   = 32'h2222_2222;
        bus.Shifter_out = 32'h3333_3333;
        bus.Compare_out = 1'b1;
        bus.in_valid           = 1'b1;
        bus.Instruction_to_ALU = vop[0];
        bus.in_rd              = 5'd1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_data !== vexp[i] || bus.wb_rd !== 5'(i + 1)
                || bus.wb_we !== 1'b1) begin
                errors++;
                $display("FAIL op%0d_result got=%0b/%h/%0d/%0b want=1/%h/%0d/1", vop[i],
                         bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_we, vexp[i], i + 1);
            end
`ifdef ALU_RESULT_FWD_EN
            checks++;
            if (fwd_valid !== 1'b1 || fwd_data !== vexp[i] || fwd_rd !== 5'(i + 1)) begin
                errors++; $display("FAIL op%0d_fwd got=%0b/%h/%0d", vop[i], fwd_valid, fwd_data, fwd_rd);
            end
`endif
            if (i < 9) begin
                bus.Instruction_to_ALU = vop[i+1];
                bus.in_rd              = 5'(i + 2);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        step();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got=%0b want=0", bus.wb_valid); end
    endtask

    task automatic test_flush();
        bus.wb_ready = 1'b0;
        drive(5'd0, 32'hB1, 5'd5);
        step();
        drive(5'd0, 32'hB2, 5'd6);
        step();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_two_ready got=%0b want=0", bus.in_ready); end
        drive(5'd0, 32'hB3, 5'd7);
        bus.in_flush = 1'b1;
        step();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b want=0", bus.wb_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0b want=1", bus.in_ready); end
        bus.in_flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        step();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_nothing_emitted got=%0b want=0", bus.wb_valid); end
        // Flushed illegal accept from EMPTY: discarded and must not set the sticky error.
        drive(5'd5, 32'hB4, 5'd8);
        bus.in_flush = 1'b1;
        step();
        bus.in_flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.err_illegal !== 1'b0) begin
            errors++; $display("FAIL flush_beats_accept got=%0b/%0b want=0/0", bus.wb_valid, bus.err_illegal);
        end
    endtask

    task automatic test_illegal();
        bus.wb_ready           = 1'b1;
        bus.in_valid           = 1'b1;
        bus.Instruction_to_ALU = 5'd2;
        bus.Compare_out        = 1'b1;
        bus.in_rd              = 5'd0;
        step();
        bus.Instruction_to_ALU = 5'd5;
        bus.in_rd              = 5'd7;
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h1 || bus.wb_we !== 1'b0 || bus.wb_rd !== 5'd0) begin
            errors++; $display("FAIL slt_rd0 got=%0b/%h/%0b want=1/00000001/0", bus.wb_valid, bus.wb_data, bus.wb_we);
        end
`ifdef ALU_RESULT_FWD_EN
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL slt_rd0_fwd got=%0b want=0", fwd_valid); end
`endif
        checks++; if (bus.err_illegal !== 1'b0) begin errors++; $display("FAIL err_early got=%0b want=0", bus.err_illegal); end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0 || bus.wb_we !== 1'b0 || bus.wb_rd !== 5'd7) begin
            errors++; $display("FAIL illegal_entry got=%0b/%h/%0b/%0d want=1/0/0/7", bus.wb_valid, bus.wb_data, bus.wb_we, bus.wb_rd);
        end
        checks++; if (bus.err_illegal !== 1'b1) begin errors++; $display("FAIL err_set got=%0b want=1", bus.err_illegal); end
        step();
        step();
        checks++; if (bus.err_illegal !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b want=1", bus.err_illegal); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL illegal_drained got=%0b want=0", bus.wb_valid); end
    endtask

    task automatic test_back_to_back();
        bus.wb_ready = 1'b0;
        drive(5'd0, 32'hA1, 5'd1);
        step();
        checks++; if (bus.in_ready !== 1'b1 || bus.wb_data !== 32'hA1) begin errors++; $display("FAIL b2b_first got=%0b/%h want=1/a1", bus.in_ready, bus.wb_data); end
        drive(5'd0, 32'hA2, 5'd2);
        step();
        checks++; if (bus.in_ready !== 1'b0 || bus.wb_data !== 32'hA1) begin errors++; $display("FAIL b2b_full got=%0b/%h want=0/a1", bus.in_ready, bus.wb_data); end
        drive(5'd0, 32'hA3, 5'd3);
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hA1
                || bus.wb_rd !== 5'd1 || bus.wb_we !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got=%0b/%0b/%h/%0d want=0/1/a1/1", k, bus.in_ready, bus.wb_valid, bus.wb_data, bus.wb_rd);
            end
        end
        bus.wb_ready = 1'b1;
        step();
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hA2 || bus.wb_rd !== 5'd2 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL drain_second got=%0b/%h/%0d/%0b want=1/a2/2/1", bus.wb_valid, bus.wb_data, bus.wb_rd, bus.in_ready);
        end
`ifdef ALU_RESULT_FWD_EN
        checks++; if (fwd_valid !== 1'b1 || fwd_data !== 32'hA2) begin errors++; $display("FAIL drain_fwd got=%0b/%h", fwd_valid, fwd_data); end
`endif
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hA3 || bus.wb_rd !== 5'd3) begin
            errors++; $display("FAIL drain_third got=%0b/%h/%0d want=1/a3/3", bus.wb_valid, bus.wb_data, bus.wb_rd);
        end
        step();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b want=0", bus.wb_valid); end
    endtask

    task automatic test_reset_mid();
        bus.wb_ready = 1'b0;
        drive(5'd0, 32'hC1, 5'd9);
        step();
        drive(5'd0, 32'hC2, 5'd10);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_two got=%0b want=0", bus.in_ready); end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'h0 || bus.wb_rd !== 5'd0 || bus.wb_we !== 1'b0) begin
            errors++; $display("FAIL rstmid_out got=%0b/%h/%0d/%0b want=0/0/0/0", bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_we);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.err_illegal !== 1'b0) begin
            errors++; $display("FAIL rstmid_state got=%0b/%0b want=1/0", bus.in_ready, bus.err_illegal);
        end
        #2 rst = 1'b0;
        bus.wb_ready = 1'b1;
        step();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after got=%0b want=0", bus.wb_valid); end
    endtask

    initial begin
        test_reset();
        test_select();
        test_flush();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
